// File: rtl/csr_pkg.sv
// Shared CSR slave definitions: handshake state encoding, half-select codes, and a half-merge helper.
// No logic of its own; no latency.
// No flow control here; the slaves that import it carry the backpressure.
package csr_pkg;

  // Handshake FSM encoding shared by every CSR slave.
  typedef enum logic [1:0] {
    CSR_IDLE = 2'd0,
    CSR_ACK  = 2'd1,
    CSR_HOLD = 2'd2
  } csr_state_t;

  // Half select on the 32-bit CSR bus.
  localparam logic CSR_SEL_LO = 1'b0;
  localparam logic CSR_SEL_HI = 1'b1;

  // Replace one 32-bit half of a 64-bit register and keep the other half unchanged.
  function automatic logic [63:0] csr_merge_half(input logic [63:0] cur,
                                                 input logic        half_sel,
                                                 input logic [31:0] wdata);
    logic [63:0] res;
    res = cur;
    if (half_sel == CSR_SEL_HI) begin
      res[63:32] = wdata;
    end else begin
      res[31:0] = wdata;
    end
    return res;
  endfunction

endpackage

// File: rtl/csr_handshake.sv
// CSR slave handshake FSM: turns a level cyc request into one accept pulse and one ack cycle.
// accept is combinational in IDLE; ack is high in the cycle after the accept edge.
// The master holds cyc until ack; the FSM then waits in HOLD for cyc to drop, so one request gives one transaction.
module csr_handshake
  import csr_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic cyc,
  output logic accept,
  output logic ack
);

  csr_state_t state_q;
  csr_state_t state_d;

  // Next-state logic: IDLE -> ACK on request, ACK -> HOLD/IDLE, HOLD -> IDLE once cyc drops.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CSR_IDLE: if (cyc)  state_d = CSR_ACK;
      CSR_ACK:  state_d = cyc ? CSR_HOLD : CSR_IDLE;
      CSR_HOLD: if (!cyc) state_d = CSR_IDLE;
      default:  state_d = CSR_IDLE;
    endcase
  end

  // State register; reset drops any pending ack immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CSR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ack is a pure state decode, so asynchronous reset clears it at once.
  assign accept = (state_q == CSR_IDLE) && cyc;
  assign ack    = (state_q == CSR_ACK);

endmodule

// File: rtl/csr_counter64.sv
// 64-bit event counter CSR slave with split lo/hi access and a coherent high-half snapshot.
// Read data and ack appear one cycle after acceptance; count_o reflects an inc one cycle later.
// The master holds cyc until ack; writes take priority over a same-edge increment.
module csr_counter64
  import csr_pkg::*;
#(
  parameter logic [63:0] RESET_VALUE = 64'h0,
  parameter bit          SNAPSHOT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_i,
  input  logic        wr,
  input  logic        cyc,
  input  logic        sel,
  input  logic        inc,
  input  logic        inhibit,
  output logic [31:0] data_o,
  output logic        ack,
  output logic [63:0] count_o
);

  logic        accept;
  logic        wr_acc;
  logic        rd_acc;

  logic [63:0] count_q,     count_d;
  logic [31:0] shadow_hi_q, shadow_hi_d;
  logic        shadow_vld_q, shadow_vld_d;
  logic [31:0] rdata_q,     rdata_d;

  csr_handshake u_hs (
    .clk    (clk),
    .rst    (rst),
    .cyc    (cyc),
    .accept (accept),
    .ack    (ack)
  );

  assign wr_acc = accept & wr;
  assign rd_acc = accept & ~wr;

  // Counter update: a software write replaces one half and suppresses that edge's increment.
  always_comb begin
    count_d = count_q;
    if (wr_acc) begin
      count_d = csr_merge_half(count_q, sel, data_i);
    end else if (inc && !inhibit) begin
      count_d = count_q + 64'd1;
    end
  end

  // Snapshot: a lo read captures the high half so the following hi read is coherent.
  always_comb begin
    shadow_hi_d  = shadow_hi_q;
    shadow_vld_d = shadow_vld_q;
    if (wr_acc) begin
      shadow_vld_d = 1'b0;
    end else if (rd_acc) begin
      if (sel == CSR_SEL_HI) begin
        shadow_vld_d = 1'b0;
      end else if (SNAPSHOT_EN) begin
        shadow_hi_d  = count_q[63:32];
        shadow_vld_d = 1'b1;
      end
    end
  end

  // Read mux, sampled from the pre-edge counter value on the acceptance edge.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_acc) begin
      if (sel == CSR_SEL_HI) begin
        rdata_d = shadow_vld_q ? shadow_hi_q : count_q[63:32];
      end else begin
        rdata_d = count_q[31:0];
      end
    end
  end

  // State registers for counter, shadow and read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q      <= RESET_VALUE;
      shadow_hi_q  <= 32'h0;
      shadow_vld_q <= 1'b0;
      rdata_q      <= 32'h0;
    end else begin
      count_q      <= count_d;
      shadow_hi_q  <= shadow_hi_d;
      shadow_vld_q <= shadow_vld_d;
      rdata_q      <= rdata_d;
    end
  end

  // Read data is only driven while ack is high; ack clears asynchronously on reset.
  assign data_o  = ack ? rdata_q : 32'h0;
  assign count_o = count_q;

endmodule

// File: tb/tb_csr_counter64.sv
// Directed bench for csr_counter64: reset, carry/wrap, snapshot, write priority, held cyc, inhibit and async reset.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected values are hand-computed constants.
module tb_csr_counter64;
  import csr_pkg::*;

  localparam logic [63:0] RST_VAL = 64'h5;

  logic        clk;
  logic        rst;
  logic [31:0] data_i;
  logic        wr;
  logic        cyc;
  logic        sel;
  logic        inc;
  logic        inhibit;
  logic [31:0] data_o;
  logic        ack;
  logic [63:0] count_o;

  int n_cmp;
  int n_bad;

  csr_counter64 #(
    .RESET_VALUE (RST_VAL),
    .SNAPSHOT_EN (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .wr      (wr),
    .cyc     (cyc),
    .sel     (sel),
    .inc     (inc),
    .inhibit (inhibit),
    .data_o  (data_o),
    .ack     (ack),
    .count_o (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction, called at a falling edge with cyc low and the FSM idle.
  // Returns the ack, data_o and count_o seen in the cycle after acceptance.
  task automatic csr_txn(input logic w, input logic s, input logic [31:0] d,
                         output logic got_ack, output logic [31:0] rd, output logic [63:0] cnt);
    cyc    = 1'b1;
    wr     = w;
    sel    = s;
    data_i = d;
    @(negedge clk);
    got_ack = ack;
    rd      = data_o;
    cnt     = count_o;
    cyc     = 1'b0;
    wr      = 1'b0;
    @(negedge clk);
  endtask

  logic        t_ack;
  logic [31:0] t_rd;
  logic [63:0] t_cnt;
  int          ack_seen;

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b0;
    data_i  = 32'h0;
    wr      = 1'b0;
    cyc     = 1'b0;
    sel     = 1'b0;
    inc     = 1'b0;
    inhibit = 1'b0;

    // Reset / idle
    @(negedge clk);
    check_eq("rst_count", count_o, 64'h5);
    check_eq("rst_ack", 64'(ack), 64'h0);
    check_eq("rst_data", 64'(data_o), 64'h0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("idle_count", count_o, 64'h5);
    inc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("inc_ack_low", 64'(ack), 64'h0);
    end
    inc = 1'b0;
    check_eq("inc3_count", count_o, 64'h8);

    // Carry and wrap
    csr_txn(1'b1, CSR_SEL_LO, 32'hFFFF_FFFF, t_ack, t_rd, t_cnt);
    check_eq("wr_lo_ack", 64'(t_ack), 64'h1);
    check_eq("wr_lo_count", t_cnt, 64'h0000_0000_FFFF_FFFF);
    csr_txn(1'b1, CSR_SEL_HI, 32'hFFFF_FFFF, t_ack, t_rd, t_cnt);
    check_eq("wr_hi_count", t_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    inc = 1'b1;
    @(negedge clk);
    inc = 1'b0;
    check_eq("wrap_count", count_o, 64'h0);
    csr_txn(1'b0, CSR_SEL_HI, 32'h0, t_ack, t_rd, t_cnt);
    check_eq("wrap_rd_hi_ack", 64'(t_ack), 64'h1);
    check_eq("wrap_rd_hi", 64'(t_rd), 64'h0);
    check_eq("idle_data_zero", 64'(data_o), 64'h0);

    // Snapshot across a low-to-high carry
    csr_txn(1'b1, CSR_SEL_LO, 32'hFFFF_FFFE, t_ack, t_rd, t_cnt);
    check_eq("snap_setup", count_o, 64'h0000_0000_FFFF_FFFE);
    inc = 1'b1;
    csr_txn(1'b0, CSR_SEL_LO, 32'h0, t_ack, t_rd, t_cnt);
    check_eq("snap_rd_lo", 64'(t_rd), 64'hFFFF_FFFE);
    csr_txn(1'b0, CSR_SEL_HI, 32'h0, t_ack, t_rd, t_cnt);
    check_eq("snap_rd_hi", 64'(t_rd), 64'h0);
    check_eq("snap_live_hi", 64'(t_cnt[63:32]), 64'h1);
    inc = 1'b0;
    check_eq("snap_after", count_o, 64'h1_0000_0002);

    // Write priority over a same-edge increment
    inc = 1'b1;
    csr_txn(1'b1, CSR_SEL_LO, 32'h10, t_ack, t_rd, t_cnt);
    check_eq("prio_ack_lo", 64'(t_cnt[31:0]), 64'h10);
    check_eq("prio_next_lo", 64'(count_o[31:0]), 64'h11);
    inc = 1'b0;

    // Held cyc with changing write data
    ack_seen = 0;
    cyc    = 1'b1;
    wr     = 1'b1;
    sel    = CSR_SEL_LO;
    data_i = 32'hA0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (ack) ack_seen++;
      data_i = 32'hA0 + 32'(i);
    end
    cyc = 1'b0;
    wr  = 1'b0;
    @(negedge clk);
    check_eq("held_ack_count", 64'(ack_seen), 64'h1);
    check_eq("held_count", count_o, 64'h1_0000_00A0);

    // Inhibit blocks counting
    inhibit = 1'b1;
    inc     = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("inhibit_count", count_o, 64'h1_0000_00A0);

    // Asynchronous reset during the ack cycle
    cyc = 1'b1;
    wr  = 1'b0;
    sel = CSR_SEL_LO;
    @(negedge clk);
    check_eq("pre_rst_ack", 64'(ack), 64'h1);
    check_eq("pre_rst_data", 64'(data_o), 64'hA0);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_ack", 64'(ack), 64'h0);
    check_eq("arst_data", 64'(data_o), 64'h0);
    check_eq("arst_count", count_o, 64'h5);
    check_eq("arst_state", 64'(dut.u_hs.state_q), 64'(CSR_IDLE));
    cyc     = 1'b0;
    inc     = 1'b0;
    inhibit = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ack", 64'(ack), 64'h0);
    csr_txn(1'b0, CSR_SEL_LO, 32'h0, t_ack, t_rd, t_cnt);
    check_eq("reissue_ack", 64'(t_ack), 64'h1);
    check_eq("reissue_rd", 64'(t_rd), 64'h5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
